// File: rtl/lc3_dmem_responder_if.sv
// lc3_dmem_responder_if: memaccess_out data-memory bus.
// The master side (MemAccess stage / testbench) drives the request fields.
// The slave side (lc3_dmem_responder) returns data, the ready strobe, busy and the error flag.
interface lc3_dmem_responder_if;
    logic        DMem_en;
    logic [15:0] DMem_addr;
    logic        DMem_rd;
    logic [15:0] DMem_din;
    logic [15:0] DMem_dout;
    logic        DMem_ready;
    logic        DMem_busy;
    logic        DMem_err;

    modport master (
        output DMem_en, DMem_addr, DMem_rd, DMem_din,
        input  DMem_dout, DMem_ready, DMem_busy, DMem_err
    );

    modport slave (
        input  DMem_en, DMem_addr, DMem_rd, DMem_din,
        output DMem_dout, DMem_ready, DMem_busy, DMem_err
    );
endinterface

// File: rtl/lc3_dmem_responder.sv
// lc3_dmem_responder: data memory behind the LC3 memaccess_out bus.
// - 2^ADDR_WIDTH x 16-bit array, cleared by an INIT sweep after every reset.
// - Each accepted request is answered WAIT_STATES+1 cycles later with a one-cycle DMem_ready.
// - Optional macro LC3_DMEM_RANGE_CHECK_EN: when defined, addresses with any bit above
//   ADDR_WIDTH set are rejected (read returns 0, write dropped) and DMem_err latches.
//   When undefined, upper address bits alias and DMem_err is tied low.
module lc3_dmem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    lc3_dmem_responder_if.slave  bus
);

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [2:0] WAIT_LOAD = 3'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
    localparam bit         ZERO_WAIT = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Control state
    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   init_cnt_reg;
    logic [2:0]              wait_cnt_reg;

    // Captured request
    logic [ADDR_WIDTH-1:0]   req_addr_reg;
    logic                    req_oor_reg;
    logic                    req_rd_reg;
    logic [15:0]             req_din_reg;

    // Registered outputs
    logic                    ready_reg;
    logic                    busy_reg;
    logic                    dout_from_mem_reg;
    logic [15:0]             dout_hold_reg;
    logic [15:0]             mem_q_reg;

    // Storage array (no reset, so it maps onto block RAM)
    logic [15:0]             mem [DEPTH];

    // Access path: the request seen at the edge that enters RESP
    logic                    take_idle;
    logic                    in_oor;
    logic                    acc_fire;
    logic                    acc_rd;
    logic                    acc_oor;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [15:0]             acc_din;
    logic                    mem_we;
    logic                    mem_re;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [15:0]             mem_wdata;

`ifdef LC3_DMEM_RANGE_CHECK_EN
    logic                    err_reg;

    // Any set bit above the array index makes the incoming address out of range.
    assign in_oor = |bus.DMem_addr[15:ADDR_WIDTH];
`else
    // Upper address bits alias; they are intentionally not looked at.
    logic                    unused_addr_hi;

    assign in_oor         = 1'b0;
    assign unused_addr_hi = |bus.DMem_addr[15:ADDR_WIDTH];
`endif

    // Select the live bus request (zero-wait accept) or the captured one (end of WAIT).
    always_comb begin
        take_idle = (state_reg == ST_IDLE) && bus.DMem_en;
        acc_fire  = 1'b0;
        acc_rd    = req_rd_reg;
        acc_oor   = req_oor_reg;
        acc_addr  = req_addr_reg;
        acc_din   = req_din_reg;
        if (state_reg == ST_IDLE) begin
            acc_rd   = bus.DMem_rd;
            acc_oor  = in_oor;
            acc_addr = bus.DMem_addr[ADDR_WIDTH-1:0];
            acc_din  = bus.DMem_din;
        end
        // Reset on the commit edge discards the request, so a pending write never lands.
        if (!reset) begin
            if (ZERO_WAIT && take_idle) begin
                acc_fire = 1'b1;
            end else if ((state_reg == ST_WAIT) && (wait_cnt_reg == 3'd0)) begin
                acc_fire = 1'b1;
            end
        end
    end

    // Single write port shared by the INIT sweep and committed writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_waddr = acc_addr;
        mem_wdata = acc_din;
        if (!reset && (state_reg == ST_INIT)) begin
            mem_we    = 1'b1;
            mem_waddr = init_cnt_reg;
            mem_wdata = 16'h0000;
        end else if (acc_fire && !acc_oor) begin
            mem_we = !acc_rd;
            mem_re = acc_rd;
        end
    end

    // Array write and registered read.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (mem_re) begin
            mem_q_reg <= mem[acc_addr];
        end
    end

    // Control FSM with registered handshake outputs and response source selection.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg         <= ST_INIT;
            init_cnt_reg      <= '0;
            wait_cnt_reg      <= 3'd0;
            req_addr_reg      <= '0;
            req_oor_reg       <= 1'b0;
            req_rd_reg        <= 1'b0;
            req_din_reg       <= 16'h0000;
            ready_reg         <= 1'b0;
            busy_reg          <= 1'b1;
            dout_from_mem_reg <= 1'b0;
            dout_hold_reg     <= 16'h0000;
`ifdef LC3_DMEM_RANGE_CHECK_EN
            err_reg           <= 1'b0;
`endif
        end else begin
            ready_reg <= 1'b0;
            case (state_reg)
                ST_INIT: begin
                    init_cnt_reg <= init_cnt_reg + 1'b1;
                    if (&init_cnt_reg) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (bus.DMem_en) begin
                        req_addr_reg <= bus.DMem_addr[ADDR_WIDTH-1:0];
                        req_oor_reg  <= in_oor;
                        req_rd_reg   <= bus.DMem_rd;
                        req_din_reg  <= bus.DMem_din;
                        busy_reg     <= 1'b1;
                        if (ZERO_WAIT) begin
                            state_reg <= ST_RESP;
                            ready_reg <= 1'b1;
                        end else begin
                            state_reg    <= ST_WAIT;
                            wait_cnt_reg <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_reg == 3'd0) begin
                        state_reg <= ST_RESP;
                        ready_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 3'd1;
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_INIT;
                    busy_reg  <= 1'b1;
                end
            endcase

            // Response data is fixed on the edge that enters RESP and held until the next one.
            if (acc_fire) begin
                if (acc_rd && !acc_oor) begin
                    dout_from_mem_reg <= 1'b1;
                end else begin
                    dout_from_mem_reg <= 1'b0;
                    dout_hold_reg     <= acc_oor ? 16'h0000 : acc_din;
                end
`ifdef LC3_DMEM_RANGE_CHECK_EN
                if (acc_oor) begin
                    err_reg <= 1'b1;
                end
`endif
            end
        end
    end

    assign bus.DMem_dout  = dout_from_mem_reg ? mem_q_reg : dout_hold_reg;
    assign bus.DMem_ready = ready_reg;
    assign bus.DMem_busy  = busy_reg;
`ifdef LC3_DMEM_RANGE_CHECK_EN
    assign bus.DMem_err   = err_reg;
`else
    assign bus.DMem_err   = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_dmem_responder.sv
// tb_lc3_dmem_responder: scoreboard bench for lc3_dmem_responder.
// Three instances: main (ADDR_WIDTH=8, WAIT_STATES=1), zero-wait and seven-wait (ADDR_WIDTH=4).
module tb_lc3_dmem_responder;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    lc3_dmem_responder_if bus_m ();
    lc3_dmem_responder_if bus0 ();
    lc3_dmem_responder_if bus7 ();

    lc3_dmem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(1)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_m.slave)
    );

    lc3_dmem_responder #(.ADDR_WIDTH(4), .WAIT_STATES(0)) u_ws0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0.slave)
    );

    lc3_dmem_responder #(.ADDR_WIDTH(4), .WAIT_STATES(7)) u_ws7 (
        .clock (clock),
        .reset (reset),
        .bus   (bus7.slave)
    );

    typedef struct {
        int          sel;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return bus_m.DMem_busy;
            1:       return bus0.DMem_busy;
            default: return bus7.DMem_busy;
        endcase
    endfunction

    function automatic logic get_ready(input int sel);
        case (sel)
            0:       return bus_m.DMem_ready;
            1:       return bus0.DMem_ready;
            default: return bus7.DMem_ready;
        endcase
    endfunction

    function automatic logic [15:0] get_dout(input int sel);
        case (sel)
            0:       return bus_m.DMem_dout;
            1:       return bus0.DMem_dout;
            default: return bus7.DMem_dout;
        endcase
    endfunction

    task automatic drive(input int sel, input logic en, input logic rd,
                         input logic [15:0] addr, input logic [15:0] din);
        case (sel)
            0: begin
                bus_m.DMem_en = en; bus_m.DMem_rd = rd; bus_m.DMem_addr = addr; bus_m.DMem_din = din;
            end
            1: begin
                bus0.DMem_en = en; bus0.DMem_rd = rd; bus0.DMem_addr = addr; bus0.DMem_din = din;
            end
            default: begin
                bus7.DMem_en = en; bus7.DMem_rd = rd; bus7.DMem_addr = addr; bus7.DMem_din = din;
            end
        endcase
    endtask

    // One request: wait for idle, accept, measure latency, check data, ready width and hold.
    task automatic issue(input int sel, input logic rd, input logic [15:0] addr,
                         input logic [15:0] din, input logic [15:0] exp_data,
                         input int exp_lat, input string name);
        int          n;
        exp_t        e;
        logic [15:0] held;
        n = 0;
        while (get_busy(sel) && n < 2000) begin
            @(posedge clock); #1; n++;
        end
        tests_run++;
        if (get_busy(sel) !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s idle_timeout: busy=%b after %0d cycles, required 0", name, get_busy(sel), n);
            return;
        end
        drive(sel, 1'b1, rd, addr, din);
        sb.push_back('{sel, exp_data});
        @(posedge clock); #1;
        // Scramble the bus after capture; the in-flight request must not notice.
        drive(sel, 1'b0, ~rd, 16'($urandom), 16'($urandom));
        n = 1;
        while (!get_ready(sel) && n < 20) begin
            @(posedge clock); #1; n++;
        end
        e = sb.pop_front();
        tests_run++;
        if (get_ready(sel) !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s ready_timeout: ready=%b, required 1 within 20 cycles", name, get_ready(sel));
            return;
        end
        tests_run++;
        if (n !== exp_lat) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d cycles, required %0d", name, n, exp_lat);
        end
        tests_run++;
        if (get_dout(sel) !== e.data) begin
            tests_failed++;
            $display("FAIL %s dout: got %h, required %h", name, get_dout(sel), e.data);
        end
        held = get_dout(sel);
        @(posedge clock); #1;
        tests_run++;
        if (get_ready(sel) !== 1'b0 || get_busy(sel) !== 1'b0 || get_dout(sel) !== e.data) begin
            tests_failed++;
            $display("FAIL %s after_resp: ready=%b busy=%b dout=%h, required ready=0 busy=0 dout=%h",
                     name, get_ready(sel), get_busy(sel), get_dout(sel), held);
        end
        $display("[TB] %s sel=%0d rd=%b addr=%h din=%h -> dout=%h lat=%0d", name, sel, rd, addr, din, held, n);
    endtask

    task automatic test_reset();
        int done_m;
        int done0;
        int done7;
        done_m = -1; done0 = -1; done7 = -1;
        repeat (3) @(posedge clock);
        #1;
        tests_run++;
        if (bus_m.DMem_busy !== 1'b1 || bus_m.DMem_ready !== 1'b0 ||
            bus_m.DMem_dout !== 16'h0000 || bus_m.DMem_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: busy=%b ready=%b dout=%h err=%b, required 1 0 0000 0",
                     bus_m.DMem_busy, bus_m.DMem_ready, bus_m.DMem_dout, bus_m.DMem_err);
        end
        reset = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            if (done_m < 0 && bus_m.DMem_busy === 1'b0) done_m = n - 1;
            if (done0 < 0 && bus0.DMem_busy === 1'b0) done0 = n - 1;
            if (done7 < 0 && bus7.DMem_busy === 1'b0) done7 = n - 1;
            @(posedge clock); #1;
        end
        tests_run++;
        if (done_m !== 256) begin
            tests_failed++;
            $display("FAIL init_len_main: busy for %0d cycles, required 256", done_m);
        end
        tests_run++;
        if (done0 !== 16 || done7 !== 16) begin
            tests_failed++;
            $display("FAIL init_len_small: busy for %0d/%0d cycles, required 16/16", done0, done7);
        end
        $display("[TB] init sweep lengths main=%0d ws0=%0d ws7=%0d", done_m, done0, done7);
        issue(0, 1'b1, 16'h0000, 16'h0, 16'h0000, 2, "init_read_0");
        issue(0, 1'b1, 16'h0012, 16'h0, 16'h0000, 2, "init_read_12");
        issue(0, 1'b1, 16'h00FF, 16'h0, 16'h0000, 2, "init_read_ff");
    endtask

    task automatic test_write_read();
        issue(0, 1'b0, 16'h0012, 16'hBEEF, 16'hBEEF, 2, "write_beef");
        issue(0, 1'b1, 16'h0012, 16'h0000, 16'hBEEF, 2, "read_beef");
    endtask

    task automatic test_wait_states();
        issue(1, 1'b1, 16'h0003, 16'h0000, 16'h0000, 1, "ws0_init_read");
        issue(1, 1'b0, 16'h0003, 16'h5A5A, 16'h5A5A, 1, "ws0_write");
        issue(1, 1'b1, 16'h0003, 16'h0000, 16'h5A5A, 1, "ws0_read");
        issue(2, 1'b0, 16'h000E, 16'hC3C3, 16'hC3C3, 8, "ws7_write");
        issue(2, 1'b1, 16'h000E, 16'h0000, 16'hC3C3, 8, "ws7_read");
    endtask

    // DMem_en held across WAIT/RESP: only the IDLE-sampled address is served.
    task automatic test_en_held();
        exp_t e;
        issue(0, 1'b0, 16'h0030, 16'h7777, 16'h7777, 2, "held_prep");
        drive(0, 1'b1, 1'b1, 16'h0012, 16'h0000);
        sb.push_back('{0, 16'hBEEF});
        @(posedge clock); #1;
        tests_run++;
        if (bus_m.DMem_busy !== 1'b1 || bus_m.DMem_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL held_wait: busy=%b ready=%b, required 1 0", bus_m.DMem_busy, bus_m.DMem_ready);
        end
        drive(0, 1'b1, 1'b1, 16'h0044, 16'h0000);
        @(posedge clock); #1;
        e = sb.pop_front();
        tests_run++;
        if (bus_m.DMem_ready !== 1'b1 || bus_m.DMem_dout !== e.data) begin
            tests_failed++;
            $display("FAIL held_resp1: ready=%b dout=%h, required 1 %h", bus_m.DMem_ready, bus_m.DMem_dout, e.data);
        end
        drive(0, 1'b1, 1'b1, 16'h0030, 16'h0000);
        sb.push_back('{0, 16'h7777});
        @(posedge clock); #1;
        tests_run++;
        if (bus_m.DMem_busy !== 1'b0 || bus_m.DMem_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL held_idle: busy=%b ready=%b, required 0 0", bus_m.DMem_busy, bus_m.DMem_ready);
        end
        @(posedge clock); #1;
        tests_run++;
        if (bus_m.DMem_busy !== 1'b1 || bus_m.DMem_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL held_accept2: busy=%b ready=%b, required 1 0", bus_m.DMem_busy, bus_m.DMem_ready);
        end
        drive(0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        @(posedge clock); #1;
        e = sb.pop_front();
        tests_run++;
        if (bus_m.DMem_ready !== 1'b1 || bus_m.DMem_dout !== e.data) begin
            tests_failed++;
            $display("FAIL held_resp2: ready=%b dout=%h, required 1 %h", bus_m.DMem_ready, bus_m.DMem_dout, e.data);
        end
        @(posedge clock); #1;
        tests_run++;
        if (bus_m.DMem_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL held_ready_width: ready=%b, required 0", bus_m.DMem_ready);
        end
        $display("[TB] en_held served 0012 then 0030, dout=%h", bus_m.DMem_dout);
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [8];
        for (int i = 0; i < 8; i++) begin
            vals[i] = 16'($urandom);
            issue(0, 1'b0, 16'h0080 + 16'(i * 16), vals[i], vals[i], 2, "b2b_write");
        end
        for (int i = 7; i >= 0; i--) begin
            issue(0, 1'b1, 16'h0080 + 16'(i * 16), 16'h0000, vals[i], 2, "b2b_read");
        end
    endtask

    task automatic test_reset_abort();
        drive(0, 1'b1, 1'b0, 16'h0005, 16'h1234);
        @(posedge clock); #1;
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        reset = 1'b1;
        @(posedge clock); #1;
        tests_run++;
        if (bus_m.DMem_busy !== 1'b1 || bus_m.DMem_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_reset: busy=%b ready=%b, required 1 0", bus_m.DMem_busy, bus_m.DMem_ready);
        end
        reset = 1'b0;
        $display("[TB] reset asserted during WAIT of write 1234 -> 0005");
        issue(0, 1'b1, 16'h0005, 16'h0000, 16'h0000, 2, "abort_read");
    endtask

    task automatic test_range();
        logic exp_err;
        logic [15:0] exp_wr;
        logic [15:0] exp_rd;
`ifdef LC3_DMEM_RANGE_CHECK_EN
        exp_err = 1'b1; exp_wr = 16'h0000; exp_rd = 16'h0000;
`else
        exp_err = 1'b0; exp_wr = 16'hAAAA; exp_rd = 16'hAAAA;
`endif
        tests_run++;
        if (bus_m.DMem_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL range_err_pre: err=%b, required 0", bus_m.DMem_err);
        end
        issue(0, 1'b0, 16'h0105, 16'hAAAA, exp_wr, 2, "range_write");
        tests_run++;
        if (bus_m.DMem_err !== exp_err) begin
            tests_failed++;
            $display("FAIL range_err_set: err=%b, required %b", bus_m.DMem_err, exp_err);
        end
        issue(0, 1'b1, 16'h0005, 16'h0000, exp_rd, 2, "range_read_alias");
        issue(0, 1'b1, 16'h0012, 16'h0000, 16'h0000, 2, "range_read_inrange");
        tests_run++;
        if (bus_m.DMem_err !== exp_err) begin
            tests_failed++;
            $display("FAIL range_err_sticky: err=%b, required %b", bus_m.DMem_err, exp_err);
        end
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
        test_reset();
        test_write_read();
        test_wait_states();
        test_en_held();
        test_back_to_back();
        test_reset_abort();
        test_range();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lc3_dmem_responder.md
# lc3_dmem_responder

Synthesizable data-memory responder for the LC3 memaccess_out bus. It is the memory-side counterpart of the MemAccess stage and accepts `DMem_addr`/`DMem_rd`/`DMem_din` requests. It returns read data on `DMem_dout`, with a programmable wait-state count and a one-cycle ready strobe. After reset it clears its array through an internal init sweep. It sits in the testbench and emulation top level as the data memory behind the memaccess_out bus.

## Interface
- `ADDR_WIDTH`, default 8: array depth is 2^ADDR_WIDTH 16-bit words; legal range 4..12.
- `WAIT_STATES`, default 1: wait cycles between request accept and response; legal range 0..7.
- `clock`  input  1: sole clock; all logic on rising edge.
- `reset`  input  1: synchronous, active-high.
- `DMem_en`  input  1: request valid; sampled only in IDLE.
- `DMem_addr`  input  16: word address.
- `DMem_rd`  input  1: 1 = read, 0 = write.
- `DMem_din`  input  16: write data.
- `DMem_dout`  output  16: response data, registered.
- `DMem_ready`  output  1: one-cycle response strobe.
- `DMem_busy`  output  1: high whenever state != IDLE.
- `DMem_err`  output  1: sticky out-of-range flag (see Configuration).

## Operation
- State machine: INIT, IDLE, WAIT, RESP.
- INIT:
  - Init counter walks 0..2^ADDR_WIDTH-1 and writes 16'h0000 to one word per cycle.
  - After the last word, go to IDLE. INIT lasts exactly 2^ADDR_WIDTH cycles.
- IDLE:
  - If `DMem_en`=1, capture addr/rd/din into request registers.
  - If WAIT_STATES>0, go to WAIT and load the wait counter with WAIT_STATES-1. Otherwise go to RESP.
- WAIT: decrement the counter. At 0, go to RESP.
- RESP:
  - Assert `DMem_ready` for this cycle only; return to IDLE next.
  - `DMem_dout` is valid this cycle and holds until the next RESP.
- Read: `DMem_dout` = array[captured addr low ADDR_WIDTH bits], taken at the WAIT→RESP (or IDLE→RESP) edge.
- Write:
  - The array word updates at the same edge.
  - `DMem_dout` echoes the captured `DMem_din`.
  - A read issued after a write's RESP sees the new data.
- `DMem_en` outside IDLE is ignored, not queued. The requester must hold or reissue it after `DMem_busy` falls.
- Inputs change after capture without effect on the in-flight request.

## Timing
- Reset values:
  - State INIT, init counter 0, wait counter 0.
  - `DMem_dout`=16'h0000, `DMem_ready`=0, `DMem_busy`=1, `DMem_err`=0.
  - Array contents are undefined until the INIT sweep completes.
- Request accepted at the edge ending IDLE cycle T. `DMem_ready` is high in cycle T+1+WAIT_STATES.
- Throughput: one request per WAIT_STATES+2 cycles. IDLE lasts at least one cycle between responses.
- `DMem_busy` is high from cycle T+1 through the RESP cycle inclusive, and high throughout INIT.
- Reset asserted in any state:
  - The in-flight request is discarded; a pending write does not commit.
  - The INIT sweep restarts from address 0.
  - `DMem_err` clears.
- Reset deasserted: INIT begins in the first cycle with `reset`=0.

## Configuration
- Macro `LC3_DMEM_RANGE_CHECK_EN`.
- Defined:
  - A request with any of `DMem_addr[15:ADDR_WIDTH]` nonzero is out of range.
  - Out-of-range read returns 16'h0000. Out-of-range write is dropped and `DMem_dout` returns 16'h0000.
  - In both cases `DMem_err` sets at the RESP edge and stays set until reset.
  - Timing and handshake are unchanged.
- Undefined:
  - Upper address bits are ignored and addresses alias modulo 2^ADDR_WIDTH.
  - `DMem_err` is tied to 0.

## Test plan
- Reset release, ADDR_WIDTH=8: `DMem_busy`=1 for exactly 256 cycles, then 0. Reading any address returns 16'h0000.
- WAIT_STATES=1: write 16'hBEEF to 16'h0012 accepted at cycle T; `DMem_ready` pulses at T+2 with `DMem_dout`=16'hBEEF. A read of 16'h0012 then returns 16'hBEEF, with `DMem_ready` two cycles after its accept.
- WAIT_STATES=0 and WAIT_STATES=7: ready latency is 1 and 8 cycles after accept, respectively. `DMem_ready` is never high for two consecutive cycles.
- `DMem_en` held high with changing addresses during WAIT: only the IDLE-sampled address is served. The next accept occurs in the IDLE cycle after RESP.
- Reset asserted during WAIT of a write of 16'h1234 to 16'h0005: after INIT completes, a read of 16'h0005 returns 16'h0000.
- `LC3_DMEM_RANGE_CHECK_EN` defined, write 16'hAAAA to 16'h0105 (ADDR_WIDTH=8): `DMem_err`=1 sticky, and a read of 16'h0005 returns 16'h0000. Undefined: the same read returns 16'hAAAA and `DMem_err` stays 0.
